// File: rtl/ttt_move_generator.sv
// Multi-cycle tic-tac-toe move picker: win scan, optional block scan, then a fallback pick.
// Define TTT_BLOCK_SEARCH_EN to compile in the BLOCK scan pass.
module ttt_move_generator #(
  parameter int PREFER_CENTER = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [3:0] computer_position,
  output logic       pc,
  output logic       no_move,
  output logic       busy
);
  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WIN      = 3'd1,
`ifdef TTT_BLOCK_SEARCH_EN
    S_BLOCK    = 3'd2,
`endif
    S_FALLBACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [8:0][1:0] board_q, board_d;
  logic [2:0]      line_q, line_d;
  logic [3:0]      pos_q, pos_d;
  logic            pc_q, pc_d;
  logic            no_move_q, no_move_d;
  logic            busy_q, busy_d;

  // Packed {a, b, c} cell indices of a line.
  function automatic logic [11:0] line_cells(input logic [2:0] line);
    case (line)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // Returns {hit, empty index}: hit means two cells owned by side and one empty.
  function automatic logic [4:0] line_hit(input logic [8:0][1:0] b, input logic [2:0] line,
                                          input logic [1:0] side);
    logic [11:0] cells;
    logic [1:0]  c0, c1, c2;
    logic [1:0]  n_side, n_empty;
    logic [3:0]  idx;
    cells   = line_cells(line);
    c0      = b[cells[11:8]];
    c1      = b[cells[7:4]];
    c2      = b[cells[3:0]];
    n_side  = {1'b0, c0 == side} + {1'b0, c1 == side} + {1'b0, c2 == side};
    n_empty = {1'b0, c0 == CELL_EMPTY} + {1'b0, c1 == CELL_EMPTY} + {1'b0, c2 == CELL_EMPTY};
    if (c0 == CELL_EMPTY)      idx = cells[11:8];
    else if (c1 == CELL_EMPTY) idx = cells[7:4];
    else                       idx = cells[3:0];
    return {(n_side == 2'd2) && (n_empty == 2'd1), idx};
  endfunction

  // Returns {found, index}: center first when preferred, else lowest empty cell.
  function automatic logic [4:0] fallback_pick(input logic [8:0][1:0] b);
    logic       found;
    logic [3:0] idx;
    found = 1'b0;
    idx   = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (!found && b[i[3:0]] == CELL_EMPTY) begin
        found = 1'b1;
        idx   = i[3:0];
      end
    end
    if (PREFER_CENTER != 0 && b[4] == CELL_EMPTY) begin
      found = 1'b1;
      idx   = 4'd4;
    end
    return {found, idx};
  endfunction

  logic [4:0] win_res, fb_res;
  assign win_res = line_hit(board_q, line_q, CELL_COMPUTER);
  assign fb_res  = fallback_pick(board_q);
`ifdef TTT_BLOCK_SEARCH_EN
  logic [4:0] blk_res;
  assign blk_res = line_hit(board_q, line_q, CELL_PLAYER);
`endif

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    line_d    = line_q;
    pos_d     = pos_q;
    pc_d      = 1'b0;
    no_move_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          board_d = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
          line_d  = 3'd0;
          state_d = S_WIN;
        end
      end
      S_WIN: begin
        if (win_res[4]) begin
          pos_d   = win_res[3:0];
          pc_d    = 1'b1;
          state_d = S_DONE;
        end else if (line_q == 3'd7) begin
          line_d  = 3'd0;
`ifdef TTT_BLOCK_SEARCH_EN
          state_d = S_BLOCK;
`else
          state_d = S_FALLBACK;
`endif
        end else begin
          line_d = line_q + 3'd1;
        end
      end
`ifdef TTT_BLOCK_SEARCH_EN
      S_BLOCK: begin
        if (blk_res[4]) begin
          pos_d   = blk_res[3:0];
          pc_d    = 1'b1;
          state_d = S_DONE;
        end else if (line_q == 3'd7) begin
          line_d  = 3'd0;
          state_d = S_FALLBACK;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
`endif
      S_FALLBACK: begin
        if (fb_res[4]) begin
          pos_d = fb_res[3:0];
          pc_d  = 1'b1;
        end else begin
          no_move_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      line_q    <= '0;
      pos_q     <= '0;
      pc_q      <= 1'b0;
      no_move_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      line_q    <= line_d;
      pos_q     <= pos_d;
      pc_q      <= pc_d;
      no_move_q <= no_move_d;
      busy_q    <= busy_d;
    end
  end

  assign computer_position = pos_q;
  assign pc                = pc_q;
  assign no_move           = no_move_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_ttt_move_generator.sv
// Bench for ttt_move_generator: hand vector table, corner sequences, and random boards vs a line-scan model.
module tb_ttt_move_generator;
`ifdef TTT_BLOCK_SEARCH_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            req = 1'b0;
  logic [8:0][1:0] drv = '0;
  logic [3:0]      computer_position;
  logic            pc, no_move, busy;

  int checks = 0;
  int errors = 0;
  int exp_pos = 0;

  always #5 clock = ~clock;

  ttt_move_generator #(.PREFER_CENTER(1)) dut (
    .clock(clock), .reset(reset), .req(req),
    .pos1(drv[0]), .pos2(drv[1]), .pos3(drv[2]), .pos4(drv[3]), .pos5(drv[4]),
    .pos6(drv[5]), .pos7(drv[6]), .pos8(drv[7]), .pos9(drv[8]),
    .computer_position(computer_position), .pc(pc), .no_move(no_move), .busy(busy)
  );

  typedef struct {
    string           name;
    logic [8:0][1:0] b;
    int              idx_blk, lat_blk; bit nm_blk;
    int              idx_nob, lat_nob; bit nm_nob;
  } vec_t;

  vec_t vecs[9];
  int   lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [8:0][1:0] bd(input int p1, p2, p3, p4, p5, p6, p7, p8, p9);
    logic [8:0][1:0] r;
    r = {2'(p9), 2'(p8), 2'(p7), 2'(p6), 2'(p5), 2'(p4), 2'(p3), 2'(p2), 2'(p1)};
    return r;
  endfunction

  function automatic vec_t mk(input string n, input logic [8:0][1:0] b,
                              input int ib, lb, input bit nb, input int in_, ln, input bit nn);
    vec_t v;
    v.name = n; v.b = b;
    v.idx_blk = ib; v.lat_blk = lb; v.nm_blk = nb;
    v.idx_nob = in_; v.lat_nob = ln; v.nm_nob = nn;
    return v;
  endfunction

  // Reference: scan lines for a computer pair, then (if enabled) a player pair, then center/lowest empty.
  function automatic void model(input logic [8:0][1:0] b, output int idx, output bit nm, output int lat);
    int c[9];
    int own, emp, e;
    for (int i = 0; i < 9; i++) c[i] = int'(b[i]);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1 && !BLK) break;
      for (int k = 0; k < 8; k++) begin
        own = 0; emp = 0; e = 0;
        for (int j = 2; j >= 0; j--) begin
          if (c[lines[k][j]] == (pass == 0 ? 2 : 1)) own++;
          if (c[lines[k][j]] == 0) begin emp++; e = lines[k][j]; end
        end
        if (own == 2 && emp == 1) begin
          idx = e; nm = 1'b0; lat = (pass == 0) ? k + 1 : 9 + k;
          return;
        end
      end
    end
    lat = BLK ? 17 : 9;
    nm = 1'b1; idx = -1;
    if (c[4] == 0) begin nm = 1'b0; idx = 4; return; end
    for (int i = 0; i < 9; i++)
      if (c[i] == 0) begin nm = 1'b0; idx = i; return; end
  endfunction

  task automatic run_req(input string name, input logic [8:0][1:0] b,
                         input int e_idx, input bit e_nm, input int e_lat);
    int lat;
    int got_pos;
    bit got_pc, got_nm;
    lat = -1; got_pos = -1; got_pc = 0; got_nm = 0;
    @(posedge clock); #1;
    drv = b; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    check({name, "_busy_E"}, busy, 1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (pc || no_move) begin
        lat = n; got_pos = computer_position; got_pc = pc; got_nm = no_move;
        check({name, "_busy_done"}, busy, 1);
        break;
      end
      check({name, "_busy"}, busy, 1);
    end
    check({name, "_latency"}, lat, e_lat);
    check({name, "_pc"}, got_pc, !e_nm);
    check({name, "_no_move"}, got_nm, e_nm);
    if (!e_nm) exp_pos = e_idx;
    check({name, "_position"}, got_pos, exp_pos);
    @(posedge clock); #1;
    check({name, "_busy_after"}, busy, 0);
    check({name, "_strobe_after"}, pc | no_move, 0);
  endtask

  initial begin
    int ri, rl, rnd;
    bit rn;
    logic [8:0][1:0] rb;
    int npc, first_lat, got;
    int pc_cyc[$];

    vecs[0] = mk("empty",        bd(0,0,0,0,0,0,0,0,0), 4, 17, 0, 4, 9, 0);
    vecs[1] = mk("win_over_blk", bd(2,2,0,1,1,0,0,0,0), 2, 1, 0, 2, 1, 0);
    vecs[2] = mk("block_L2",     bd(0,0,0,0,0,0,1,1,0), 8, 11, 0, 4, 9, 0);
    vecs[3] = mk("full_board",   bd(2,1,2,2,1,1,1,2,2), -1, 17, 1, -1, 9, 1);
    vecs[4] = mk("center_taken", bd(0,0,0,0,1,0,0,0,0), 0, 17, 0, 0, 9, 0);
    vecs[5] = mk("win_L7",       bd(0,0,2,0,2,0,0,0,0), 6, 8, 0, 6, 8, 0);
    vecs[6] = mk("first_hit_L4", bd(2,2,3,0,2,0,0,0,0), 7, 5, 0, 7, 5, 0);
    vecs[7] = mk("cell11_inert", bd(3,3,0,0,0,0,0,0,0), 4, 17, 0, 4, 9, 0);
    vecs[8] = mk("block_L7",     bd(0,0,1,0,1,0,0,0,0), 6, 16, 0, 0, 9, 0);

    // Reset state
    reset = 1'b1;
    #2;
    check("reset_pos", computer_position, 0);
    check("reset_pc", pc, 0);
    check("reset_no_move", no_move, 0);
    check("reset_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      if (BLK) run_req(vecs[i].name, vecs[i].b, vecs[i].idx_blk, vecs[i].nm_blk, vecs[i].lat_blk);
      else     run_req(vecs[i].name, vecs[i].b, vecs[i].idx_nob, vecs[i].nm_nob, vecs[i].lat_nob);
    end

    // Asynchronous reset in the middle of the win scan
    @(posedge clock); #1;
    drv = vecs[0].b; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_pos", computer_position, 0);
    check("arst_pc", pc, 0);
    check("arst_busy", busy, 0);
    npc = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clock); #1;
      if (pc || no_move) npc++;
    end
    reset = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clock); #1;
      if (pc || no_move) npc++;
    end
    check("arst_no_strobe", npc, 0);
    exp_pos = 0;
    run_req("after_reset", vecs[1].b, 2, 1'b0, 1);

    // Second req while busy is ignored; board edits after the snapshot are ignored
    @(posedge clock); #1;
    drv = vecs[0].b; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    drv = vecs[1].b;
    npc = 0; first_lat = -1; got = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock); #1;
      if (pc) begin
        npc++;
        if (first_lat < 0) begin first_lat = n; got = computer_position; end
      end
      if (n == 2) req = 1'b1;
      if (n == 3) req = 1'b0;
    end
    check("busy_req_pc_count", npc, 1);
    check("snapshot_latency", first_lat, BLK ? 17 : 9);
    check("snapshot_position", got, 4);
    exp_pos = 4;

    // req held high restarts on the first idle cycle after DONE
    @(posedge clock); #1;
    drv = vecs[1].b; req = 1'b1;
    @(posedge clock); #1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clock); #1;
      if (pc) pc_cyc.push_back(n);
    end
    req = 1'b0;
    check("held_req_strobes", pc_cyc.size(), 2);
    if (pc_cyc.size() >= 2) begin
      check("held_req_first", pc_cyc[0], 1);
      check("held_req_second", pc_cyc[1], 4);
    end
    npc = 0;
    for (int n = 0; n < 40 && busy; n++) @(posedge clock);
    #1;
    check("held_req_idle", busy, 0);
    exp_pos = 2;

    // Random boards against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 9; i++) begin
        rnd = $urandom_range(0, 9);
        rb[i] = (rnd < 4) ? 2'd0 : (rnd < 7) ? 2'd1 : (rnd < 9) ? 2'd2 : 2'd3;
      end
      model(rb, ri, rn, rl);
      run_req($sformatf("rand%0d", t), rb, ri, rn, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ttt_move_generator.md
TTT_MOVE_GENERATOR -- requirements
Module: ttt_move_generator

Interface
REQ-001 SHALL have parameter PREFER_CENTER, default 1; 1 = fallback tries index 4 before the lowest-index scan, 0 = lowest-index scan only.
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req, input, 1, request for a computer move; sampled only in IDLE.
REQ-005 SHALL have ports pos1..pos9, input, 2 each, board cells (00 empty, 01 player, 10 computer, 11 treated as occupied by neither side).
REQ-006 SHALL have port computer_position, output, 4, chosen cell index 0..8 (0 = pos1 ... 8 = pos9).
REQ-007 SHALL have port pc, output, 1, one-cycle strobe qualifying computer_position.
REQ-008 SHALL have port no_move, output, 1, one-cycle strobe meaning the board had no empty cell.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, WIN, BLOCK, FALLBACK and DONE; all outputs SHALL be registered.
REQ-011 In IDLE with req=1 at edge E, the block SHALL snapshot pos1..pos9 internally, clear the line counter, and enter WIN; later board changes SHALL be ignored until the next request.
REQ-012 Line order SHALL be L0 (0,1,2), L1 (3,4,5), L2 (6,7,8), L3 (0,3,6), L4 (1,4,7), L5 (2,5,8), L6 (0,4,8), L7 (2,4,6).
REQ-013 WIN SHALL evaluate one line per cycle; a hit is exactly two cells = 10 and one cell = 00; the hit SHALL latch the empty cell index and go to DONE.
REQ-014 After L7 in WIN with no hit, the block SHALL go to BLOCK (macro on) or FALLBACK (macro off).
REQ-015 BLOCK SHALL do the same one-line-per-cycle scan with the hit condition two cells = 01 and one cell = 00; after L7 with no hit it SHALL go to FALLBACK.
REQ-016 FALLBACK SHALL take one cycle and pick index 4 if empty and PREFER_CENTER=1, else the lowest empty index; with no empty cell it SHALL flag no-move; either way it SHALL then go to DONE.
REQ-017 Within one scan pass the first hit in line order SHALL win.
REQ-018 Timing SHALL be: win on line k gives the strobe in cycle E+k+1; block on line k gives E+9+k; fallback gives E+17 (macro on) or E+9 (macro off).
REQ-019 DONE SHALL last exactly one cycle, assert pc (or no_move, never both), then return to IDLE.
REQ-020 computer_position SHALL hold its last value until the next DONE; on no-move it SHALL be left unchanged.
REQ-021 req while busy SHALL be ignored and not queued; req held high SHALL start a new request on the first IDLE cycle after DONE.

Reset
REQ-022 Reset SHALL force state IDLE, computer_position = 0, pc = 0, no_move = 0, busy = 0, and clear the snapshot and line counter immediately, without waiting for a clock edge.
REQ-023 A reset during a scan SHALL abort it with no strobe emitted; operation SHALL resume on the first req after reset deasserts.

Configuration
REQ-024 Macro TTT_BLOCK_SEARCH_EN SHALL control the BLOCK state: defined = BLOCK is compiled in; undefined = BLOCK logic is absent and WIN goes directly to FALLBACK.

Verification
REQ-025 Empty board, req at edge E -> pc=1 at E+17, computer_position=4, no_move=0 (macro on, PREFER_CENTER=1).
REQ-026 pos1=pos2=10, pos3=00, req -> pc at E+1, computer_position=2; with pos4=pos5=01, pos6=00 added, the win is still chosen.
REQ-027 pos7=pos8=01, pos9=00, no computer pair -> pc at E+11 (L2), computer_position=8; with the macro undefined -> pc at E+9 with the fallback choice.
REQ-028 Full board with no line hits -> no_move=1 at E+17, pc=0, computer_position unchanged; busy high E+1..E+17.
REQ-029 Reset asserted at E+5 mid-WIN -> outputs 0 immediately, no strobe; req after release -> normal response.
REQ-030 req pulsed again at E+3 -> ignored, exactly one pc; board changed during the scan -> result matches the snapshot taken at E.
